ctl_round: RTL and testbench
============================

# ctl_round

Game-round sequencer for Duck Hunt that generalises the fixed single-duck, constant-ammo play loop to `N_DUCKS` simultaneous ducks, per-round ammo, round counting, timeout fly-away and BCD score/ammo/round outputs. It sits in the ctrl section between `ctl_trigger` (shot/hit pulses) and the per-duck controllers and draw stages. It replaces the constant ammo digits on `disp_hex_mux` with live values.

## Interface
- `N_DUCKS`, 2: ducks launched per round (1..4)
- `AMMO`, 3: shots per round (1..9)
- `MAX_ROUNDS`, 10: rounds per game (1..99)
- `TIMEOUT_FRAMES`, 600: frames of flight before forced fly-away (≥1)
- `PAUSE_FRAMES`, 120: frames spent in `ROUND_END` (≥1)
- `SCORE_DIGITS`, 2: BCD digits of score (1..4)
- `clk` in 1: 65 MHz system clock
- `rst` in 1: asynchronous, active-low reset
- `new_frame` in 1: one-cycle pulse per VGA frame
- `start` in 1: one-cycle pulse that starts a game
- `shot_fired` in 1: one-cycle pulse for a trigger pull
- `duck_hit` in N_DUCKS: one-cycle pulse per duck hit
- `duck_gone` in N_DUCKS: one-cycle pulse when a duck leaves the screen
- `duck_launch` out N_DUCKS: one-cycle launch pulse per duck
- `duck_active` out N_DUCKS: duck is in flight and shootable
- `fly_away` out 1: level; all active ducks must exit upward
- `ammo_bcd` out 4: remaining shots
- `round_bcd` out 8: current round, two BCD digits
- `score_bcd` out 4*SCORE_DIGITS: score, BCD
- `state` out 3: IDLE=0, LAUNCH=1, FLY=2, ROUND_END=3, GAME_OVER=4
- `game_over` out 1: level while in GAME_OVER

## Operation
- IDLE: `start` → clear score, set round=1, ammo=AMMO → LAUNCH.
- LAUNCH, one cycle: pulse all `duck_launch` bits, set `duck_active`=all ones, clear the frame timer and per-round hit mask → FLY.
- FLY:
  - `shot_fired` with ammo>0 decrements ammo. With ammo=0 it is ignored.
  - `duck_hit[i]` with active[i] set: clear active[i], set mask[i], add 1 to score. Hits on inactive ducks are ignored.
  - `duck_gone[i]`: clear active[i] with no score change.
  - The frame timer counts `new_frame` pulses.
  - `fly_away` is set when ammo=0 while any duck is active, or when the timer reaches TIMEOUT_FRAMES. Once set, it stays set until the state leaves FLY.
  - When `duck_active` becomes all zeros → ROUND_END.
- ROUND_END: clear `fly_away`. After PAUSE_FRAMES `new_frame` pulses:
  - if round=MAX_ROUNDS → GAME_OVER;
  - otherwise increment round (BCD), reload ammo=AMMO → LAUNCH.
- GAME_OVER: hold score. `start` → behaves as the IDLE start.
- `start` is ignored in LAUNCH, FLY and ROUND_END.
- Score arithmetic:
  - BCD add of popcount of valid hits in the cycle, with per-digit carry.
  - Saturates at all 9s; never wraps.
- Simultaneous events in one cycle:
  - `duck_hit[i]` and `duck_gone[i]` on the same duck: hit wins, score counted.
  - `shot_fired` and `duck_hit`: both are processed.
  - Several hits in one cycle: all are counted.
  - The last duck cleared in a cycle → ROUND_END on the next cycle.

## Timing
- All outputs are registered. Each is updated on the clock edge after the causing input pulse (1-cycle latency).
- `duck_launch` is high for exactly one cycle, on the cycle after entry to LAUNCH.
- Frame counters advance only on `new_frame`. The FLY timer is compared with ≥ and saturates at TIMEOUT_FRAMES.
- Reset values (asynchronous, `rst`=0):
  - state=IDLE, `duck_launch`=0, `duck_active`=0, `fly_away`=0;
  - `ammo_bcd`=0, `round_bcd`=0, `score_bcd`=0, `game_over`=0.
- Reset mid-round abandons the round immediately. No launch pulse is emitted on release.
- Input pulses are assumed synchronous to `clk` and one cycle wide. Level inputs held high count once per cycle.

## Configuration
- `CTL_ROUND_BONUS_EN` defined:
  - on the FLY→ROUND_END transition, if mask is all ones (every duck hit), add N_DUCKS bonus points to score;
  - added in the first ROUND_END cycle, with the same saturation rule.
- Undefined: no bonus logic. Score changes only on hits.

## Test plan
- Reset: `rst`=0 mid-FLY → all outputs 0, state=0 within the same cycle, no `duck_launch` after release.
- Perfect round (N_DUCKS=2, AMMO=3): start, 2 shots each with a hit → score 02, ammo 1, ROUND_END, `round_bcd` 02 after PAUSE_FRAMES. With `CTL_ROUND_BONUS_EN` → score 04.
- Ammo exhaustion: 3 shots, no hits → ammo 0, `fly_away`=1. Both `duck_gone` → ROUND_END, score 00. A 4th shot changes nothing.
- Timeout: no shots, TIMEOUT_FRAMES `new_frame` pulses → `fly_away` rises one cycle after the last pulse.
- Simultaneous events: `duck_hit`=2'b11, `shot_fired` and `duck_gone[0]` in one cycle → score +2, ammo −1, ROUND_END next cycle.
- Saturation/game over: score preloaded to 98 via hits, 3 more hits → 99. Round MAX_ROUNDS completes → `game_over`=1; `start` → score 00, round 01.

Source files
------------

// File: rtl/ctl_round.sv
// rtl/ctl_round.sv - Duck Hunt round sequencer: launch, flight, scoring, rounds, game over
// Optional perfect-round bonus enabled by defining CTL_ROUND_BONUS_EN.
`timescale 1ns/1ps
module ctl_round #(
  parameter int N_DUCKS        = 2,
  parameter int AMMO           = 3,
  parameter int MAX_ROUNDS     = 10,
  parameter int TIMEOUT_FRAMES = 600,
  parameter int PAUSE_FRAMES   = 120,
  parameter int SCORE_DIGITS   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      new_frame,
  input  logic                      start,
  input  logic                      shot_fired,
  input  logic [N_DUCKS-1:0]        duck_hit,
  input  logic [N_DUCKS-1:0]        duck_gone,
  output logic [N_DUCKS-1:0]        duck_launch,
  output logic [N_DUCKS-1:0]        duck_active,
  output logic                      fly_away,
  output logic [3:0]                ammo_bcd,
  output logic [7:0]                round_bcd,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [2:0]                state,
  output logic                      game_over
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    FLY       = 3'd2,
    ROUND_END = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
  localparam int PW = $clog2(PAUSE_FRAMES + 1);
  localparam logic [7:0]    MAX_ROUND_BCD = 8'((MAX_ROUNDS / 10) * 16 + (MAX_ROUNDS % 10));
  localparam logic [3:0]    AMMO_INIT     = 4'(AMMO);
  localparam logic [TW-1:0] TIMEOUT       = TW'(TIMEOUT_FRAMES);
  localparam logic [PW-1:0] PAUSE_LAST    = PW'(PAUSE_FRAMES - 1);

  state_t                    st;
  logic [TW-1:0]             timer, timer_next;
  logic [PW-1:0]             pause_cnt;
  logic [N_DUCKS-1:0]        mask, hit_valid, active_next;
  logic [3:0]                ammo_next, hit_cnt;
  logic [4*SCORE_DIGITS-1:0] score_hit;
  logic [7:0]                round_inc;
  logic                      fly_next;
`ifdef CTL_ROUND_BONUS_EN
  logic                      bonus_pend;
`endif

  // Adds a small value (< 10) to a packed BCD score; a carry out of the top digit pins it at all 9s.
  function automatic logic [4*SCORE_DIGITS-1:0] bcd_add_sat(
    input logic [4*SCORE_DIGITS-1:0] s,
    input logic [3:0]                n
  );
    logic [4*SCORE_DIGITS-1:0] r;
    logic [4:0]                d;
    logic [3:0]                c;
    r = s;
    c = n;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      d = {1'b0, s[4*i +: 4]} + {1'b0, c};
      if (d > 5'd9) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        c = 4'd1;
      end else begin
        r[4*i +: 4] = d[3:0];
        c = 4'd0;
      end
    end
    if (c != 4'd0) r = {SCORE_DIGITS{4'h9}};
    return r;
  endfunction

  always_comb begin
    hit_valid = duck_hit & duck_active;
    hit_cnt   = '0;
    for (int i = 0; i < N_DUCKS; i++) hit_cnt = hit_cnt + {3'b000, hit_valid[i]};
    active_next = duck_active & ~duck_hit & ~duck_gone;
    ammo_next   = (shot_fired && ammo_bcd != 4'd0) ? ammo_bcd - 4'd1 : ammo_bcd;
    timer_next  = (new_frame && timer < TIMEOUT) ? timer + TW'(1) : timer;
    fly_next    = fly_away || (ammo_next == 4'd0 && active_next != '0) || (timer_next >= TIMEOUT);
    score_hit   = bcd_add_sat(score_bcd, hit_cnt);
    round_inc   = (round_bcd[3:0] == 4'd9) ? {round_bcd[7:4] + 4'd1, 4'd0}
                                           : {round_bcd[7:4], round_bcd[3:0] + 4'd1};
  end

  assign state = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      duck_launch <= '0;
      duck_active <= '0;
      fly_away    <= 1'b0;
      ammo_bcd    <= '0;
      round_bcd   <= '0;
      score_bcd   <= '0;
      game_over   <= 1'b0;
      timer       <= '0;
      pause_cnt   <= '0;
      mask        <= '0;
`ifdef CTL_ROUND_BONUS_EN
      bonus_pend  <= 1'b0;
`endif
    end else begin
      duck_launch <= '0;
      case (st)
        IDLE, GAME_OVER: begin
          if (start) begin
            score_bcd <= '0;
            round_bcd <= 8'h01;
            ammo_bcd  <= AMMO_INIT;
            game_over <= 1'b0;
            st        <= LAUNCH;
          end
        end
        LAUNCH: begin
          duck_launch <= '1;
          duck_active <= '1;
          timer       <= '0;
          mask        <= '0;
          st          <= FLY;
        end
        FLY: begin
          ammo_bcd    <= ammo_next;
          duck_active <= active_next;
          mask        <= mask | hit_valid;
          score_bcd   <= score_hit;
          timer       <= timer_next;
          if (active_next == '0) begin
            st        <= ROUND_END;
            fly_away  <= 1'b0;
            pause_cnt <= '0;
`ifdef CTL_ROUND_BONUS_EN
            bonus_pend <= &(mask | hit_valid);
`endif
          end else begin
            fly_away <= fly_next;
          end
        end
        ROUND_END: begin
          fly_away <= 1'b0;
`ifdef CTL_ROUND_BONUS_EN
          if (bonus_pend) begin
            score_bcd  <= bcd_add_sat(score_bcd, 4'(N_DUCKS));
            bonus_pend <= 1'b0;
          end
`endif
          if (new_frame) begin
            if (pause_cnt == PAUSE_LAST) begin
              pause_cnt <= '0;
              if (round_bcd == MAX_ROUND_BCD) begin
                st        <= GAME_OVER;
                game_over <= 1'b1;
              end else begin
                round_bcd <= round_inc;
                ammo_bcd  <= AMMO_INIT;
                st        <= LAUNCH;
              end
            end else begin
              pause_cnt <= pause_cnt + PW'(1);
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctl_round.sv
// tb/tb_ctl_round.sv - directed self-checking bench for ctl_round
`timescale 1ns/1ps
module tb_ctl_round;
  localparam int N_DUCKS        = 2;
  localparam int AMMO           = 3;
  localparam int MAX_ROUNDS     = 60;
  localparam int TIMEOUT_FRAMES = 4;
  localparam int PAUSE_FRAMES   = 2;
  localparam int SCORE_DIGITS   = 2;
`ifdef CTL_ROUND_BONUS_EN
  localparam int BONUS = N_DUCKS;
`else
  localparam int BONUS = 0;
`endif

  logic       clk = 1'b0, rst = 1'b1, new_frame = 1'b0, start = 1'b0, shot_fired = 1'b0;
  logic [1:0] duck_hit = '0, duck_gone = '0;
  logic [1:0] duck_launch, duck_active;
  logic       fly_away, game_over;
  logic [3:0] ammo_bcd;
  logic [7:0] round_bcd, score_bcd;
  logic [2:0] state;

  int checks = 0, errors = 0;
  int exp_score = 0, exp_round = 0;
  bit exp_over = 1'b0;

  ctl_round #(
    .N_DUCKS(N_DUCKS), .AMMO(AMMO), .MAX_ROUNDS(MAX_ROUNDS),
    .TIMEOUT_FRAMES(TIMEOUT_FRAMES), .PAUSE_FRAMES(PAUSE_FRAMES), .SCORE_DIGITS(SCORE_DIGITS)
  ) dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .start(start), .shot_fired(shot_fired),
    .duck_hit(duck_hit), .duck_gone(duck_gone), .duck_launch(duck_launch),
    .duck_active(duck_active), .fly_away(fly_away), .ammo_bcd(ammo_bcd),
    .round_bcd(round_bcd), .score_bcd(score_bcd), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fly_ev(input logic s, input logic [1:0] h, input logic [1:0] g, input logic f);
    shot_fired = s; duck_hit = h; duck_gone = g; new_frame = f;
    cycle();
    shot_fired = 1'b0; duck_hit = '0; duck_gone = '0; new_frame = 1'b0;
  endtask

  task automatic add_score(input int n);
    exp_score = (exp_score + n > 99) ? 99 : exp_score + n;
  endtask

  // Entered in ROUND_END; drives the pause and checks the following round or game over.
  task automatic finish_round();
    for (int i = 0; i < PAUSE_FRAMES; i++) begin
      check("pause_state", 32'(state), 3);
      new_frame = 1'b1;
      cycle();
      new_frame = 1'b0;
    end
    if (exp_round == MAX_ROUNDS) begin
      exp_over = 1'b1;
      check("over_state", 32'(state), 4);
      check("over_flag", 32'(game_over), 1);
    end else begin
      exp_round++;
      check("next_state", 32'(state), 1);
      check("next_round", 32'(round_bcd), bcd2(exp_round));
      check("next_ammo", 32'(ammo_bcd), AMMO);
    end
  endtask

  // From LAUNCH: shoot the ducks selected by hits, let the others leave, then finish the round.
  task automatic hit_round(input logic [1:0] hits);
    cycle();
    if (hits[0]) fly_ev(1'b1, 2'b01, 2'b00, 1'b0);
    if (hits[1]) fly_ev(1'b1, 2'b10, 2'b00, 1'b0);
    if (hits != 2'b11) fly_ev(1'b0, 2'b00, ~hits, 1'b0);
    add_score(int'(hits[0]) + int'(hits[1]));
    check("round_end", 32'(state), 3);
    cycle();
    if (hits == 2'b11) add_score(BONUS);
    check("round_score", 32'(score_bcd), bcd2(exp_score));
    finish_round();
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_state", 32'(state), 0);
    check("rst_launch", 32'(duck_launch), 0);
    check("rst_active", 32'(duck_active), 0);
    check("rst_fly", 32'(fly_away), 0);
    check("rst_ammo", 32'(ammo_bcd), 0);
    check("rst_round", 32'(round_bcd), 0);
    check("rst_score", 32'(score_bcd), 0);
    check("rst_over", 32'(game_over), 0);
    cycle(); cycle();
    rst = 1'b1;
    cycle();

    // Start, then reset in the middle of flight.
    start = 1'b1; cycle(); start = 1'b0;
    check("start_state", 32'(state), 1);
    cycle();
    check("fly_state", 32'(state), 2);
    check("launch_pulse", 32'(duck_launch), 3);
    check("launch_active", 32'(duck_active), 3);
    fly_ev(1'b1, 2'b00, 2'b00, 1'b0);
    check("launch_once", 32'(duck_launch), 0);
    check("shot_ammo", 32'(ammo_bcd), 2);
    #2 rst = 1'b0;
    #1;
    check("async_state", 32'(state), 0);
    check("async_active", 32'(duck_active), 0);
    check("async_ammo", 32'(ammo_bcd), 0);
    check("async_round", 32'(round_bcd), 0);
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("no_launch", 32'(duck_launch), 0);
    end
    check("idle_after", 32'(state), 0);

    // Round 1: perfect round.
    start = 1'b1; cycle(); start = 1'b0;
    exp_score = 0; exp_round = 1;
    check("g_score", 32'(score_bcd), 0);
    check("g_round", 32'(round_bcd), 8'h01);
    check("g_ammo", 32'(ammo_bcd), 3);
    cycle();
    fly_ev(1'b1, 2'b01, 2'b00, 1'b0);
    check("hit1_score", 32'(score_bcd), 1);
    check("hit1_ammo", 32'(ammo_bcd), 2);
    fly_ev(1'b1, 2'b10, 2'b00, 1'b0);
    add_score(2);
    check("hit2_score", 32'(score_bcd), 2);
    check("hit2_ammo", 32'(ammo_bcd), 1);
    check("hit2_state", 32'(state), 3);
    cycle();
    add_score(BONUS);
    check("perfect_score", 32'(score_bcd), bcd2(exp_score));
    finish_round();

    // Round 2: ammo exhaustion.
    cycle();
    fly_ev(1'b1, 2'b00, 2'b00, 1'b0);
    fly_ev(1'b1, 2'b00, 2'b00, 1'b0);
    check("ammo1_fly", 32'(fly_away), 0);
    fly_ev(1'b1, 2'b00, 2'b00, 1'b0);
    check("ammo0", 32'(ammo_bcd), 0);
    check("ammo0_fly", 32'(fly_away), 1);
    fly_ev(1'b1, 2'b00, 2'b00, 1'b0);
    check("shot4_ammo", 32'(ammo_bcd), 0);
    check("shot4_state", 32'(state), 2);
    fly_ev(1'b0, 2'b00, 2'b11, 1'b0);
    check("gone_state", 32'(state), 3);
    check("gone_fly", 32'(fly_away), 0);
    check("gone_score", 32'(score_bcd), bcd2(exp_score));
    finish_round();

    // Round 3: timeout.
    cycle();
    for (int i = 0; i < TIMEOUT_FRAMES - 1; i++) fly_ev(1'b0, 2'b00, 2'b00, 1'b1);
    check("pre_timeout", 32'(fly_away), 0);
    fly_ev(1'b0, 2'b00, 2'b00, 1'b1);
    check("timeout_fly", 32'(fly_away), 1);
    check("timeout_ammo", 32'(ammo_bcd), 3);
    fly_ev(1'b0, 2'b00, 2'b00, 1'b1);
    check("timeout_hold", 32'(fly_away), 1);
    fly_ev(1'b0, 2'b00, 2'b11, 1'b0);
    check("timeout_end", 32'(state), 3);
    finish_round();

    // Round 4: simultaneous double hit, shot and gone.
    cycle();
    fly_ev(1'b1, 2'b11, 2'b01, 1'b0);
    add_score(2);
    check("sim_score", 32'(score_bcd), bcd2(exp_score));
    check("sim_ammo", 32'(ammo_bcd), 2);
    check("sim_state", 32'(state), 3);
    check("sim_active", 32'(duck_active), 0);
    cycle();
    add_score(BONUS);
    check("sim_bonus", 32'(score_bcd), bcd2(exp_score));
    finish_round();

    // Climb to saturation, then play out the remaining rounds.
    while (exp_score < 98 && !exp_over) hit_round(2'b11);
    if (!exp_over) hit_round(2'b11);
    if (!exp_over) hit_round(2'b01);
    check("sat_score", 32'(score_bcd), 8'h99);
    while (!exp_over) hit_round(2'b00);
    check("over_score", 32'(score_bcd), 8'h99);
    cycle();
    check("over_hold", 32'(state), 4);

    start = 1'b1; cycle(); start = 1'b0;
    check("restart_score", 32'(score_bcd), 0);
    check("restart_round", 32'(round_bcd), 8'h01);
    check("restart_state", 32'(state), 1);
    check("restart_over", 32'(game_over), 0);
    check("restart_ammo", 32'(ammo_bcd), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
